// File: rtl/rv32i_lsu_pkg.sv
// rtl/rv32i_lsu_pkg.sv - shared types and helpers for the rv32i load/store unit
package rv32i_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } lsu_state_e;

  // Access size in bytes; the reserved encoding behaves as a word.
  function automatic int unsigned lsu_nbytes(input logic [1:0] size);
    case (size)
      LSU_BYTE: return 1;
      LSU_HALF: return 2;
      default:  return 4;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// rtl/rv32i_lsu_align.sv - byte-lane alignment: store shift-in or load extract/extend
module rv32i_lsu_align
  import rv32i_lsu_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int BUS_W = 16,
  localparam int STG_W = (XLEN / BUS_W + 1) * BUS_W,
  localparam int BB    = BUS_W / 8,
  localparam int LBB   = $clog2(BB),
  localparam int OFF_W = (LBB > 0) ? LBB : 1
) (
  input  logic             store_i,
  input  logic [STG_W-1:0] data_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  output logic [STG_W-1:0] data_o
);

  int unsigned      nbits;
  int unsigned      shamt;
  logic [STG_W-1:0] low_mask;
  logic [STG_W-1:0] xlen_mask;
  logic [STG_W-1:0] shifted;
  logic             sign;

  // Store: keep the addressed bytes and move them up to their lanes.
  // Load: bring the addressed bytes down to bit 0, then extend to XLEN.
  always_comb begin
    nbits     = lsu_nbytes(size_i) * 8;
    shamt     = int'(off_i) * 8;
    low_mask  = (STG_W'(1) << nbits) - STG_W'(1);
    xlen_mask = (STG_W'(1) << XLEN) - STG_W'(1);
    shifted   = (data_i >> shamt) & low_mask;
    sign      = 1'b0;
    data_o    = '0;
    if (store_i) begin
      data_o = (data_i & low_mask) << shamt;
    end else begin
      case (size_i)
        LSU_BYTE: sign = !unsigned_i && shifted[7];
        LSU_HALF: sign = !unsigned_i && shifted[15];
        default:  sign = !unsigned_i && shifted[31];
      endcase
      data_o = shifted | ({STG_W{sign}} & xlen_mask & ~low_mask);
    end
  end

endmodule

// File: rtl/rv32i_lsu.sv
// rtl/rv32i_lsu.sv - load/store unit splitting core accesses into narrow bus beats
module rv32i_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int BUS_W     = 16,
  parameter  int ADDR_W    = 32,
  localparam int BB        = BUS_W / 8,
  localparam int LBB       = $clog2(BB),
  localparam int MAX_BEATS = XLEN / BUS_W + 1,
  localparam int STG_W     = MAX_BEATS * BUS_W,
  localparam int BE_W      = MAX_BEATS * BB,
  localparam int OFF_W     = (LBB > 0) ? LBB : 1,
  localparam int BA_W      = ADDR_W - LBB,
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_valid,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [XLEN-1:0]   core_wdata,
  input  logic [1:0]        core_size,
  input  logic              core_unsigned,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [XLEN-1:0]   core_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [BA_W-1:0]   bus_addr,
  output logic [BUS_W-1:0]  bus_wdata,
  output logic [BB-1:0]     bus_be,
  input  logic              bus_busy,
  input  logic              bus_ack,
  input  logic [BUS_W-1:0]  bus_rdata
);

  lsu_state_e        state_q;
  logic [BEAT_W-1:0] k_q;
  logic [BEAT_W-1:0] nbeats_q;
  logic [BA_W-1:0]   first_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              we_q;
  logic [STG_W-1:0]  stg_q;
  logic [BE_W-1:0]   be_q;
  logic [XLEN-1:0]   rdata_q;
  logic              rvalid_q;

  logic [OFF_W-1:0]  off_d;
  logic [BEAT_W-1:0] nbeats_d;
  logic [BE_W-1:0]   be_d;
  logic [STG_W-1:0]  stg_merge;
  logic [BUS_W-1:0]  beat_wdata;
  logic [BB-1:0]     beat_be;

  logic              align_store;
  logic [STG_W-1:0]  align_in;
  logic [OFF_W-1:0]  align_off;
  logic [1:0]        align_size;
  logic              align_uns;
  logic [STG_W-1:0]  align_out;

  // Beat plan for the request presented in IDLE: offset, beat count, lane mask.
  always_comb begin
    off_d    = (LBB > 0) ? core_addr[OFF_W-1:0] : '0;
    nbeats_d = BEAT_W'((int'(off_d) + int'(lsu_nbytes(core_size)) + BB - 1) / BB);
    be_d     = ((BE_W'(1) << lsu_nbytes(core_size)) - BE_W'(1)) << off_d;
  end

  // Current beat slice selection, and staging with the arriving read beat merged in.
  always_comb begin
    stg_merge  = stg_q;
    beat_wdata = '0;
    beat_be    = '0;
    for (int b = 0; b < MAX_BEATS; b++) begin
      if (k_q == BEAT_W'(b)) begin
        stg_merge[b*BUS_W +: BUS_W] = bus_rdata;
        beat_wdata                  = stg_q[b*BUS_W +: BUS_W];
        beat_be                     = be_q[b*BB +: BB];
      end
    end
  end

  // One aligner serves both directions: store shift in IDLE, load extract otherwise.
  always_comb begin
    align_store = (state_q == IDLE);
    align_in    = align_store ? STG_W'(core_wdata) : stg_merge;
    align_off   = align_store ? off_d : off_q;
    align_size  = align_store ? core_size : size_q;
    align_uns   = align_store ? core_unsigned : uns_q;
  end

  rv32i_lsu_align #(
    .XLEN  (XLEN),
    .BUS_W (BUS_W)
  ) u_align (
    .store_i    (align_store),
    .data_i     (align_in),
    .off_i      (align_off),
    .size_i     (align_size),
    .unsigned_i (align_uns),
    .data_o     (align_out)
  );

  // Bus beat and core handshake outputs; beat fields are zero outside a request.
  always_comb begin
    bus_req     = (state_q == ISSUE) && !bus_busy;
    bus_we      = bus_req && we_q;
    bus_addr    = bus_req ? first_q + BA_W'(k_q) : '0;
    bus_wdata   = (bus_req && we_q) ? beat_wdata : '0;
    bus_be      = bus_req ? beat_be : '0;
    core_stall  = core_valid && (state_q != DONE);
    core_rvalid = rvalid_q;
    core_rdata  = rdata_q;
  end

  // Access sequencer: latch the plan, issue beats, collect acks, report completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      nbeats_q <= '0;
      first_q  <= '0;
      off_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      we_q     <= 1'b0;
      stg_q    <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (core_valid) begin
            state_q  <= ISSUE;
            k_q      <= '0;
            nbeats_q <= nbeats_d;
            first_q  <= core_addr[ADDR_W-1:LBB];
            off_q    <= off_d;
            size_q   <= core_size;
            uns_q    <= core_unsigned;
            we_q     <= core_we;
            stg_q    <= align_out;
            be_q     <= be_d;
          end
        end
        ISSUE: begin
          if (!bus_busy) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus_ack) begin
            if (!we_q) begin
              stg_q <= stg_merge;
            end
            if (BEAT_W'(k_q + 1'b1) < nbeats_q) begin
              k_q     <= k_q + 1'b1;
              state_q <= ISSUE;
            end else begin
              state_q <= DONE;
              if (!we_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= align_out[XLEN-1:0];
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb/tb_rv32i_lsu.sv - directed self-checking bench for rv32i_lsu
module tb_rv32i_lsu;

  logic        clk;
  logic        reset;
  logic        core_valid;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [1:0]  core_size;
  logic        core_unsigned;
  logic        core_stall;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [30:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [1:0]  bus_be;
  logic        bus_busy;
  logic        bus_ack;
  logic [15:0] bus_rdata;

  int n_chk;
  int n_fail;

  logic [15:0] rd_beats [8];
  logic [31:0] r_addr   [8];
  logic [1:0]  r_be     [8];
  logic [15:0] r_wd     [8];
  logic        r_we     [8];
  int          r_cyc    [8];
  int          nreq;
  int          nrv;
  int          stall_cnt;
  logic [31:0] got_rdata;

  rv32i_lsu #(
    .XLEN   (32),
    .BUS_W  (16),
    .ADDR_W (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_valid    (core_valid),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_size     (core_size),
    .core_unsigned (core_unsigned),
    .core_stall    (core_stall),
    .core_rvalid   (core_rvalid),
    .core_rdata    (core_rdata),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_be        (bus_be),
    .bus_busy      (bus_busy),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one access, plays a zero-wait responder (optionally busy at start),
  // and records every beat, stall cycle and rvalid pulse. Called at posedge+1.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic uns, input int busy_n);
    logic ack_next;
    logic done;
    nreq = 0; nrv = 0; stall_cnt = 0; got_rdata = '0;
    ack_next = 1'b0; done = 1'b0;
    core_valid = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    core_size = size; core_unsigned = uns;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      bus_ack   = ack_next;
      bus_rdata = (ack_next && nreq > 0) ? rd_beats[nreq-1] : 16'h0;
      bus_busy  = (cyc < busy_n);
      #1;
      if (core_stall) stall_cnt++;
      else done = 1'b1;
      if (bus_req && nreq < 8) begin
        r_addr[nreq] = 32'(bus_addr);
        r_be[nreq]   = bus_be;
        r_wd[nreq]   = bus_wdata;
        r_we[nreq]   = bus_we;
        r_cyc[nreq]  = cyc;
        nreq++;
      end
      ack_next = bus_req;
      if (core_rvalid) begin
        nrv++;
        got_rdata = core_rdata;
      end
      @(posedge clk); #1;
    end
    core_valid = 1'b0; bus_ack = 1'b0; bus_busy = 1'b0; bus_rdata = '0;
    check("access_completes", done, 1'b1);
    #1;
    check("rvalid_single_cycle", core_rvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; core_valid = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    core_size = 2'd0; core_unsigned = 1'b0; bus_busy = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_stall", core_stall, 1'b0);
    check("rst_rvalid", core_rvalid, 1'b0);
    check("rst_rdata", core_rdata, 32'h0);
    check("rst_req", bus_req, 1'b0);
    check("rst_be", bus_be, 2'b00);
    @(posedge clk); #1;

    // Aligned word load
    rd_beats[0] = 16'h5678; rd_beats[1] = 16'h1234;
    run_access(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0);
    check("t1_nreq", nreq, 2);
    check("t1_addr0", r_addr[0], 32'h80);
    check("t1_addr1", r_addr[1], 32'h81);
    check("t1_be0", r_be[0], 2'b11);
    check("t1_be1", r_be[1], 2'b11);
    check("t1_we0", r_we[0], 1'b0);
    check("t1_rdata", got_rdata, 32'h12345678);
    check("t1_stall", stall_cnt, 5);
    check("t1_nrv", nrv, 1);

    // Misaligned word store across three beats
    run_access(1'b1, 32'h103, 32'hAABBCCDD, 2'd2, 1'b0, 0);
    check("t2_nreq", nreq, 3);
    check("t2_addr0", r_addr[0], 32'h81);
    check("t2_addr1", r_addr[1], 32'h82);
    check("t2_addr2", r_addr[2], 32'h83);
    check("t2_be0", r_be[0], 2'b10);
    check("t2_be1", r_be[1], 2'b11);
    check("t2_be2", r_be[2], 2'b01);
    check("t2_wd0", r_wd[0], 16'hDD00);
    check("t2_wd1", r_wd[1], 16'hBBCC);
    check("t2_wd2", r_wd[2], 16'h00AA);
    check("t2_we0", r_we[0], 1'b1);
    check("t2_nrv", nrv, 0);
    check("t2_stall", stall_cnt, 7);

    // Signed and unsigned byte loads from the upper lane
    rd_beats[0] = 16'h80FF;
    run_access(1'b0, 32'h7, 32'h0, 2'd0, 1'b0, 0);
    check("t3s_addr", r_addr[0], 32'h3);
    check("t3s_be", r_be[0], 2'b10);
    check("t3s_rdata", got_rdata, 32'hFFFFFF80);
    check("t3s_stall", stall_cnt, 3);
    run_access(1'b0, 32'h7, 32'h0, 2'd0, 1'b1, 0);
    check("t3u_rdata", got_rdata, 32'h00000080);
    check("t3u_nrv", nrv, 1);

    // Half load with the controller busy for the first three cycles
    rd_beats[0] = 16'hBEEF;
    run_access(1'b0, 32'h2, 32'h0, 2'd1, 1'b0, 3);
    check("t4_nreq", nreq, 1);
    check("t4_req_cycle", r_cyc[0], 3);
    check("t4_addr", r_addr[0], 32'h1);
    check("t4_be", r_be[0], 2'b11);
    check("t4_rdata", got_rdata, 32'hFFFFBEEF);
    check("t4_stall", stall_cnt, 5);

    // Reset during the first beat's wait, followed by a stray ack
    core_valid = 1'b1; core_we = 1'b0; core_addr = 32'h200; core_size = 2'd2; core_unsigned = 1'b0;
    @(posedge clk); #1;
    #1;
    check("t5_req", bus_req, 1'b1);
    check("t5_addr", bus_addr, 31'h100);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; core_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 16'hFFFF;
    #1;
    check("t5_stall", core_stall, 1'b0);
    check("t5_rvalid", core_rvalid, 1'b0);
    check("t5_rdata", core_rdata, 32'h0);
    check("t5_req0", bus_req, 1'b0);
    check("t5_we", bus_we, 1'b0);
    check("t5_baddr", bus_addr, 31'h0);
    check("t5_wdata", bus_wdata, 16'h0);
    check("t5_be", bus_be, 2'b00);
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = '0;
    #1;
    check("t5_idle_req", bus_req, 1'b0);
    check("t5_idle_rvalid", core_rvalid, 1'b0);
    @(posedge clk); #1;

    // Misaligned word load wrapping the beat address space
    rd_beats[0] = 16'h11AA; rd_beats[1] = 16'h3322; rd_beats[2] = 16'hBB44;
    run_access(1'b0, 32'hFFFF_FFFF, 32'h0, 2'd2, 1'b0, 0);
    check("t6_nreq", nreq, 3);
    check("t6_addr0", r_addr[0], 32'h7FFF_FFFF);
    check("t6_addr1", r_addr[1], 32'h0);
    check("t6_addr2", r_addr[2], 32'h1);
    check("t6_be0", r_be[0], 2'b10);
    check("t6_be2", r_be[2], 2'b01);
    check("t6_rdata", got_rdata, 32'h44332211);
    check("t6_stall", stall_cnt, 7);

    // Reserved size behaves as a word
    rd_beats[0] = 16'hCAFE; rd_beats[1] = 16'h8BAD;
    run_access(1'b0, 32'h4, 32'h0, 2'd3, 1'b0, 0);
    check("t7_nreq", nreq, 2);
    check("t7_rdata", got_rdata, 32'h8BADCAFE);

    // Byte store drives only the addressed lane
    run_access(1'b1, 32'h4, 32'h12345699, 2'd0, 1'b0, 0);
    check("t8_nreq", nreq, 1);
    check("t8_addr", r_addr[0], 32'h2);
    check("t8_be", r_be[0], 2'b01);
    check("t8_wd", r_wd[0], 16'h0099);
    check("t8_nrv", nrv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
Name: rv32i_lsu

Overview:
Parametrised load/store unit between the rv32i core's MA stage and a narrow external memory controller (PSRAM-style, BUS_W-bit beats).
- Accepts one XLEN-wide load/store per request.
- Splits it into 1..N aligned bus beats, supporting misaligned byte, half and word accesses.
- Stalls the core until the access completes.
- Returns sign- or zero-extended load data.

Parameters:
XLEN, 32, core data width (power of two, ≥ BUS_W)
BUS_W, 16, bus beat width in bits (8, 16 or 32)
ADDR_W, 32, byte address width
BB = BUS_W/8 (derived localparam), bytes per beat
MAX_BEATS = XLEN/BUS_W+1 (derived localparam), beats for a worst-case misaligned word

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
core_valid  in  1  core request; op/addr/wdata/size/sign held stable while core_stall is high
core_we  in  1  1=store, 0=load
core_addr  in  ADDR_W  byte address
core_wdata  in  XLEN  store data, right-aligned
core_size  in  2  lsu_size_e: byte, half, word
core_unsigned  in  1  zero-extend load data when 1
core_stall  out  1  core must hold state
core_rvalid  out  1  one-cycle pulse: load data valid
core_rdata  out  XLEN  extended load data, held until next completion
bus_req  out  1  one-cycle beat request
bus_we  out  1  beat is a write
bus_addr  out  ADDR_W-log2(BB)  beat (word) address
bus_wdata  out  BUS_W  write data
bus_be  out  BB  byte enables, 1=active
bus_busy  in  1  controller cannot accept bus_req
bus_ack  in  1  beat complete, one pulse per beat
bus_rdata  in  BUS_W  read data, valid with bus_ack on reads

Behaviour:
Reset behaviour
- Synchronous; all outputs are 0 after reset, state=IDLE.
- Reset mid-access aborts it; bus_ack arriving in IDLE is ignored.

States: IDLE, ISSUE, WAIT, DONE

Beat computation
- Computed in IDLE on core_valid.
- off = addr mod BB; nbytes = 1/2/4.
- nbeats = (off+nbytes+BB-1)/BB, range 1..MAX_BEATS.
- First beat address = addr>>log2(BB).
- Byte mask and data shifted left by off into a MAX_BEATS*BUS_W-bit staging register.
- Beat k uses slice k, at address first+k.
- Beat address wraps modulo 2^(ADDR_W-log2(BB)).

core_stall
- Combinational: core_valid && state!=DONE.
- In DONE, stall is 0 and the core advances.
- A request first seen in IDLE stalls in that same cycle.

Transitions
- IDLE→ISSUE when core_valid.
- ISSUE: bus_req=1 for exactly one cycle when !bus_busy, else wait. bus_we/addr/wdata/be are valid in the bus_req cycle, then →WAIT.
- WAIT: on bus_ack, reads store bus_rdata into staging slice k, and k increments.
  - If k+1<nbeats → ISSUE.
  - Otherwise → DONE.
- bus_ack is ignored outside WAIT.
- DONE: loads pulse core_rvalid=1 and update core_rdata; stores pulse nothing. Unconditionally →IDLE.
- A new core_valid in the IDLE cycle after DONE starts a new access. Minimum of one IDLE cycle between accesses.

Latency and beats
- Latency with zero-wait bus (ack the cycle after req): 1+2*nbeats+1 cycles from request to stall release.
- Beats whose byte mask would be all-zero are never generated.
- Write beats carry only the addressed byte enables. Read beats drive bus_be to the requested lanes.

Load extraction
- Staging is shifted right by off*8 and the low nbytes are taken.
- Sign bit is the MSB of the size when core_unsigned=0; otherwise zero-extend.
- core_size=word with XLEN=32 performs no extension.
- Reserved core_size value (3) is treated as word.

Decomposition:
- rv32i package gains lsu_size_e (LSU_BYTE=0, LSU_HALF=1, LSU_WORD=2) and lsu_state_e (IDLE, ISSUE, WAIT, DONE).
- One combinational sub-module, lsu_align, handles the load path: staging, off, size and unsigned in; extended XLEN out. It is reused by the store path shift via a mode bit.
- The FSM, beat counter and staging register stay in rv32i_lsu.

Test Plan:
1. Aligned word load @0x100, BUS_W=16, acks return 0x5678 then 0x1234 → two bus_req at beat addresses 0x80 and 0x81, be=2'b11; core_rdata=0x12345678; stall high for 5 cycles; single core_rvalid pulse.
2. Misaligned word store @0x103, wdata=0xAABBCCDD → three beats: 0x81 be=10 wdata=0xDD00; 0x82 be=11 wdata=0xBBCC; 0x83 be=01 wdata=0x00AA; no core_rvalid.
3. Signed byte load @0x7, ack data 0x80FF → core_rdata=0xFFFFFF80; same with core_unsigned=1 → 0x00000080.
4. Half load @0x2 with bus_busy held high 3 cycles → bus_req delayed until busy low; exactly one req; core_rdata correct; stall covers busy period.
5. Reset asserted in WAIT of beat 1 of a 2-beat load, then a stray bus_ack → all outputs 0 next cycle; state IDLE; no core_rvalid; next request completes normally.
6. Wrap-around: word load @0xFFFF_FFFF with ADDR_W=32 → beat addresses 0x7FFF_FFFF then 0x0000_0000; data assembled across the wrap.
